// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 divider scheduler: in-flight tag
// layout, special-value encodings and the zero-exponent classifier.
package fp_div_pkg;

  localparam int TAG_ID_W = 3;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_INF = 8'hFF;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
    logic                dz;
    logic                nan;
    logic                sign;
  } tag_t;

  // Zero or denormal operands both have an all-zero exponent field
  function automatic logic is_zero_exp(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fp_div_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter: the first requester at or after the
// pointer wins, and the pointer moves past the winner when update is strobed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] win
);

  logic [PTR_W-1:0] ptr;
  logic             found;
  int               j;

  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
  end

  assign grant = found ? (N'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_scheduler.sv
// Shares one fixed-latency FP32 divider among NUM_REQ requesters; a tag shift
// register follows each operation and patches in divide-by-zero results.
module fp_div_scheduler
  import fp_div_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int XLEN        = 32,
  parameter int DIV_LATENCY = 16,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [XLEN-1:0]         div_a,
  output logic [XLEN-1:0]         div_b,
  input  logic [XLEN-1:0]         div_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_dz,
  output logic                    idle
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic               hs;
  logic [XLEN-1:0]    a_sel;
  logic [XLEN-1:0]    b_sel;
  tag_t               tag_in;
  tag_t               tag_out;
  tag_t               tag_p [DIV_LATENCY+1];
  logic               any_tag;
  logic [XLEN-1:0]    rsp_val;

  // Holding en low through reset keeps req_ready at zero while rst_n is low
  rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en & rst_n),
    .req    (req_valid),
    .update (hs),
    .grant  (grant),
    .win    (win)
  );

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign a_sel     = req_a[int'(win)*XLEN +: XLEN];
  assign b_sel     = req_b[int'(win)*XLEN +: XLEN];

  always_comb begin
    tag_in      = '0;
    tag_in.v    = hs;
    tag_in.id   = TAG_ID_W'(win);
    tag_in.dz   = is_zero_exp(b_sel);
    tag_in.nan  = is_zero_exp(b_sel) & is_zero_exp(a_sel);
    tag_in.sign = a_sel[31] ^ b_sel[31];
  end

  // Stage p0: operand issue and tag entry; bubbles drive zero operands
  always_ff @(posedge clk) begin
    div_a <= hs ? a_sel : '0;
    div_b <= hs ? b_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= DIV_LATENCY; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= hs ? tag_in : '0;
      for (int k = 1; k <= DIV_LATENCY; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k <= DIV_LATENCY; k++) any_tag = any_tag | tag_p[k].v;
  end

  assign tag_out = tag_p[DIV_LATENCY];

  always_comb begin
    rsp_val = div_result;
    if (tag_out.nan) rsp_val = FP_QNAN;
    else if (tag_out.dz) rsp_val = {tag_out.sign, FP_EXP_INF, 23'd0};
  end

  // Response stage: the last tag lines up with the divider output this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_dz     <= 1'b0;
    end else begin
      rsp_valid  <= tag_out.v;
      rsp_id     <= tag_out.v ? ID_W'(tag_out.id) : '0;
      rsp_result <= tag_out.v ? rsp_val : '0;
      rsp_dz     <= tag_out.v & tag_out.dz;
    end
  end

  // The response register still carries an operation until it is presented
  assign idle = !any_tag && !hs && !rsp_valid;

endmodule
